// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory bus arbiter.
//   arb_state_t     - arbiter FSM states
//   ARB_BEATS       - default data beats per cache line
//   TAG_WRITE_BIT   - request tag bit that marks a write (SYSBUS_WRITE)
//   beat_cnt_width  - beat counter width derived from the beat count
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    localparam int ARB_BEATS     = 8;
    localparam int TAG_WRITE_BIT = 12;

    // One spare bit above log2(beats).
    function automatic int beat_cnt_width(input int beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// arb2_pick: combinational two-way request picker.
//   req[1:0]   - request lines, bit n = port n
//   last_grant - port granted most recently (round-robin only)
//   grant      - index of the winning port (meaningful when |req)
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - contested requests go to the port that is not last_grant
//   undefined - fixed priority, port 1 always wins
module arb2_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = ~last_grant;
        end
    end
`else
    // Fixed priority has no use for the history bit.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = req[1];
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the DRAM-side system bus between the instruction
// cache (port 0) and the data cache (port 1). A granted transaction runs to
// completion: address beat, then BEATS write-data or read-response beats.
//   clk, reset              - clock, synchronous active-high reset
//   cN_req*/cN_resp*        - cache-side bus ports (N = 0, 1)
//   m_bus_req*/m_bus_resp*  - top-level memory bus
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on contest,
// otherwise port 1 has fixed priority).
//
// state | meaning
// IDLE  | no owner, all outputs 0, picks a winner when any port requests
// ADDR  | owner address beat forwarded to the memory bus
// WDATA | owner write-data beats forwarded, counted on reqcyc && reqack
// RDATA | memory response beats routed to owner, counted on respcyc && respack
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = ARB_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      c0_reqcyc,
    output logic                      c0_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    output logic                      c0_respcyc,
    input  logic                      c0_respack,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,

    input  logic                      c1_reqcyc,
    output logic                      c1_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    output logic                      c1_respcyc,
    input  logic                      c1_respack,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,

    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

    localparam int CNT_W = beat_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t       state;
    logic             owner;
    logic             is_write;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_grant;
    logic             pick;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Constant under fixed priority; no history register exists.
    assign last_grant = 1'b1;
`endif

    arb2_pick u_pick (
        .req        ({c1_reqcyc, c0_reqcyc}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // Owner-side views of the requester inputs.
    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;
    logic                      fwd_req;
    logic                      fwd_resp;

    assign own_reqcyc  = owner ? c1_reqcyc  : c0_reqcyc;
    assign own_req     = owner ? c1_req     : c0_req;
    assign own_reqtag  = owner ? c1_reqtag  : c0_reqtag;
    assign own_respack = owner ? c1_respack : c0_respack;
    assign fwd_req     = (state == ADDR) || (state == WDATA);
    assign fwd_resp    = (state == RDATA);

    assign m_bus_reqcyc  = fwd_req && own_reqcyc;
    assign m_bus_req     = fwd_req ? own_req    : '0;
    assign m_bus_reqtag  = fwd_req ? own_reqtag : '0;
    assign m_bus_respack = fwd_resp && own_respack;

    assign c0_reqack  = fwd_req && !owner && m_bus_reqack;
    assign c1_reqack  = fwd_req &&  owner && m_bus_reqack;
    assign c0_respcyc = fwd_resp && !owner && m_bus_respcyc;
    assign c1_respcyc = fwd_resp &&  owner && m_bus_respcyc;
    assign c0_resp    = (fwd_resp && !owner) ? m_bus_resp    : '0;
    assign c1_resp    = (fwd_resp &&  owner) ? m_bus_resp    : '0;
    assign c0_resptag = (fwd_resp && !owner) ? m_bus_resptag : '0;
    assign c1_resptag = (fwd_resp &&  owner) ? m_bus_resptag : '0;

    logic req_hs;
    logic resp_hs;
    assign req_hs  = m_bus_reqcyc && m_bus_reqack;
    assign resp_hs = m_bus_respcyc && m_bus_respack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            is_write <= 1'b0;
            beat_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (c0_reqcyc || c1_reqcyc) begin
                        owner    <= pick;
                        is_write <= pick ? c1_reqtag[TAG_WRITE_BIT] : c0_reqtag[TAG_WRITE_BIT];
                        state    <= ADDR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= pick;
`endif
                    end
                end
                ADDR: begin
                    if (req_hs) begin
                        beat_cnt <= '0;
                        state    <= is_write ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (req_hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                RDATA: begin
                    if (resp_hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Build with +define+MEM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  reqcyc;
    logic [1:0]  reqack;
    logic [63:0] req [2];
    logic [12:0] reqtag [2];
    logic [1:0]  respcyc;
    logic [1:0]  respack;
    logic [63:0] resp [2];
    logic [12:0] resptag [2];
    logic        m_bus_reqcyc;
    logic        m_bus_reqack;
    logic [63:0] m_bus_req;
    logic [12:0] m_bus_reqtag;
    logic        m_bus_respcyc;
    logic        m_bus_respack;
    logic [63:0] m_bus_resp;
    logic [12:0] m_bus_resptag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .c0_reqcyc     (reqcyc[0]),
        .c0_reqack     (reqack[0]),
        .c0_req        (req[0]),
        .c0_reqtag     (reqtag[0]),
        .c0_respcyc    (respcyc[0]),
        .c0_respack    (respack[0]),
        .c0_resp       (resp[0]),
        .c0_resptag    (resptag[0]),
        .c1_reqcyc     (reqcyc[1]),
        .c1_reqack     (reqack[1]),
        .c1_req        (req[1]),
        .c1_reqtag     (reqtag[1]),
        .c1_respcyc    (respcyc[1]),
        .c1_respack    (respack[1]),
        .c1_resp       (resp[1]),
        .c1_resptag    (resptag[1]),
        .m_bus_reqcyc  (m_bus_reqcyc),
        .m_bus_reqack  (m_bus_reqack),
        .m_bus_req     (m_bus_req),
        .m_bus_reqtag  (m_bus_reqtag),
        .m_bus_respcyc (m_bus_respcyc),
        .m_bus_respack (m_bus_respack),
        .m_bus_resp    (m_bus_resp),
        .m_bus_resptag (m_bus_resptag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every DUT output must be zero (IDLE or just after reset).
    task automatic check_all_zero(input string tag);
        check({tag, "_mreqcyc"}, m_bus_reqcyc, 0);
        check({tag, "_mreq"}, m_bus_req | 64'(m_bus_reqtag), 0);
        check({tag, "_mrespack"}, m_bus_respack, 0);
        check({tag, "_reqack"}, reqack, 0);
        check({tag, "_respcyc"}, respcyc, 0);
        check({tag, "_resp"}, resp[0] | resp[1] | 64'(resptag[0]) | 64'(resptag[1]), 0);
    endtask

    function automatic logic [12:0] mk_tag(input int p, input bit wr);
        return {wr, 12'hA00 | 12'(p)};
    endfunction

    task automatic raise(input int p, input bit wr, input logic [63:0] addr);
        reqcyc[p] = 1'b1;
        req[p]    = addr;
        reqtag[p] = mk_tag(p, wr);
    endtask

    task automatic do_reset();
        reqcyc = '0; respack = '0;
        req[0] = '0; req[1] = '0; reqtag[0] = '0; reqtag[1] = '0;
        m_bus_reqack = 0; m_bus_respcyc = 0; m_bus_resp = '0; m_bus_resptag = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_all_zero("reset");
    endtask

    // Entered at posedge+1 of an IDLE cycle with the requester already raised.
    // Returns in the IDLE cycle after the transaction (or after an abort).
    task automatic txn(input int who, input bit wr, input logic [63:0] addr,
                       input int stall_beat, input int stall_len, input int abort_beat);
        int oth = 1 - who;
        logic [1:0] onehot = (who == 1) ? 2'b10 : 2'b01;
        #1;
        check("idle_mreqcyc", m_bus_reqcyc, 0);
        check("idle_reqack", reqack, 0);
        check("idle_respcyc", respcyc, 0);
        step();
        check("grant_reqcyc", m_bus_reqcyc, 1);
        check("grant_addr", m_bus_req, addr);
        check("grant_tag", 64'(m_bus_reqtag), 64'(mk_tag(who, wr)));
        check("grant_ack_pre", reqack, 0);
        m_bus_reqack = 1'b1;
        #1;
        check("addr_ack", reqack, onehot);
        step();
        if (wr) begin
            for (int b = 0; b < 8; b++) begin
                req[who] = 64'h11 * (b + 1);
                if (b == abort_beat) begin
                    m_bus_respcyc = 1'b1;
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    #1;
                    check_all_zero("abort");
                    reqcyc[who] = 1'b0; m_bus_reqack = 1'b0; m_bus_respcyc = 1'b0;
                    return;
                end
                #1;
                check("wbeat_cyc", m_bus_reqcyc, 1);
                check("wbeat_data", m_bus_req, 64'h11 * (b + 1));
                check("wbeat_ack", reqack, onehot);
                check("wbeat_resp", respcyc | 2'(resp[oth] != 0), 0);
                step();
            end
        end else begin
            reqcyc[who]   = 1'b0;
            respack[oth]  = 1'b1;
            m_bus_respcyc = 1'b1;
            for (int b = 0; b < 8; b++) begin
                m_bus_resp    = 64'hD000 + 64'(b);
                m_bus_resptag = 13'h100 + 13'(b);
                if (b == stall_beat) begin
                    for (int s = 0; s < stall_len; s++) begin
                        respack[who] = 1'b0;
                        #1;
                        check("stall_mrespack", m_bus_respack, 0);
                        check("stall_respcyc", respcyc, onehot);
                        step();
                    end
                end
                respack[who] = 1'b1;
                #1;
                check("rbeat_mrespack", m_bus_respack, 1);
                check("rbeat_respcyc", respcyc, onehot);
                check("rbeat_data", resp[who], 64'hD000 + 64'(b));
                check("rbeat_tag", 64'(resptag[who]), 64'(13'h100 + 13'(b)));
                check("rbeat_oth", resp[oth] | 64'(resptag[oth]), 0);
                check("rbeat_reqack", reqack, 0);
                step();
            end
        end
        // Handshake inputs still active: a ninth beat must not be accepted.
        check("end_mreqcyc", m_bus_reqcyc, 0);
        check("end_reqack", reqack, 0);
        check("end_respcyc", respcyc, 0);
        check("end_mrespack", m_bus_respack, 0);
        reqcyc[who] = 1'b0; respack = '0;
        m_bus_reqack = 1'b0; m_bus_respcyc = 1'b0;
    endtask

    initial begin
        int w;
        do_reset();

        raise(0, 1'b0, 64'h1000);
        txn(0, 1'b0, 64'h1000, -1, 0, -1);

        raise(1, 1'b1, 64'h2000);
        txn(1, 1'b1, 64'h2000, -1, 0, -1);

        raise(0, 1'b0, 64'h3000);
        txn(0, 1'b0, 64'h3000, 4, 3, -1);

        // Port 0 waits through port 1's read (port 1 wins in both policies here).
        raise(0, 1'b0, 64'h5000);
        raise(1, 1'b0, 64'h4000);
        txn(1, 1'b0, 64'h4000, -1, 0, -1);
        txn(0, 1'b0, 64'h5000, -1, 0, -1);

        // Contests start from a fresh reset so round-robin begins with port 0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = k % 2;
`else
            w = 1;
`endif
            raise(0, 1'b0, 64'h8000 + 64'(k));
            raise(1, 1'b0, 64'h9000 + 64'(k));
            txn(w, 1'b0, (w == 1) ? 64'h9000 + 64'(k) : 64'h8000 + 64'(k), -1, 0, -1);
        end
        txn(0, 1'b0, 64'h8003, -1, 0, -1);

        raise(1, 1'b1, 64'h6000);
        txn(1, 1'b1, 64'h6000, -1, 0, 5);
        raise(0, 1'b0, 64'h7000);
        txn(0, 1'b0, 64'h7000, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
